// File: rtl/load_store_unit.sv
`default_nettype none
// =============================================================================
// load_store_unit : single-outstanding load/store unit between pipeline and bus
// Revision: 1.0
// =============================================================================
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 15
) (
    input  logic            CLK,
    input  logic            Reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_load,
    input  logic [2:0]      req_func3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [4:0]      req_rd,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic [4:0]      resp_rd,
    output logic            resp_err,
    output logic            stall,
    input  logic            flush,
    output logic [XLEN-1:0] MEM_addr,
    output logic [XLEN-1:0] MEM_WR_out,
    output logic [2:0]      MEM_type,
    output logic            MEM_rd_en,
    output logic            MEM_wr_en,
    input  logic [XLEN-1:0] MEM_data,
    input  logic            MEM_ack,
    input  logic            MEM_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t          state;
    logic [7:0]      cnt;
    logic            ready_q, rd_en_q, wr_en_q, resp_q, err_q, load_q, flushed;
    logic [2:0]      func3_q;
    logic [XLEN-1:0] addr_q, wdata_q, data_q;
    logic [4:0]      rd_q;

    logic            accept, illegal, misaligned, mem_active;
    logic [XLEN-1:0] store_data, load_ext;

    // A flush in IDLE vetoes acceptance of a simultaneous request.
    assign accept = req_valid && ready_q && !flush;

    always_comb begin
        illegal = (req_func3 == 3'b111);
        if (XLEN == 32 && (req_func3 == 3'b011 || req_func3 == 3'b110))
            illegal = 1'b1;
        if (!req_load && (req_func3 > ((XLEN == 32) ? 3'b010 : 3'b011)))
            illegal = 1'b1;

        case (req_func3[1:0])
            2'b01:   misaligned = req_addr[0];
            2'b10:   misaligned = |req_addr[1:0];
            2'b11:   misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase

        case (req_func3[1:0])
            2'b00:   store_data = XLEN'(req_wdata[7:0]);
            2'b01:   store_data = XLEN'(req_wdata[15:0]);
            2'b10:   store_data = XLEN'(req_wdata[31:0]);
            default: store_data = req_wdata;
        endcase

        case (func3_q)
            3'b000:  load_ext = XLEN'($signed(MEM_data[7:0]));
            3'b001:  load_ext = XLEN'($signed(MEM_data[15:0]));
            3'b010:  load_ext = XLEN'($signed(MEM_data[31:0]));
            3'b100:  load_ext = XLEN'(MEM_data[7:0]);
            3'b101:  load_ext = XLEN'(MEM_data[15:0]);
            3'b110:  load_ext = XLEN'(MEM_data[31:0]);
            default: load_ext = MEM_data;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            ready_q <= 1'b0;
            rd_en_q <= 1'b0;
            wr_en_q <= 1'b0;
            resp_q  <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
            flushed <= 1'b0;
            func3_q <= 3'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            rd_q    <= 5'd0;
        end else begin
            resp_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        ready_q <= 1'b0;
                        flushed <= 1'b0;
                        load_q  <= req_load;
                        func3_q <= req_func3;
                        addr_q  <= req_addr;
                        wdata_q <= req_load ? '0 : store_data;
                        rd_q    <= req_load ? req_rd : 5'd0;
                        data_q  <= '0;
                        if (illegal || misaligned) begin
                            state  <= RESP;
                            resp_q <= 1'b1;
                            err_q  <= 1'b1;
                        end else begin
                            state   <= WAIT;
                            cnt     <= 8'd0;
                            rd_en_q <= req_load;
                            wr_en_q <= !req_load;
                        end
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (flush)
                        flushed <= 1'b1;
                    if (MEM_ack || cnt == CNT_LAST) begin
                        rd_en_q <= 1'b0;
                        wr_en_q <= 1'b0;
                        // A flushed transaction has nothing to report, so skip RESP.
                        if (flushed || flush) begin
                            state   <= IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            state  <= RESP;
                            resp_q <= 1'b1;
                            err_q  <= MEM_ack ? MEM_err : 1'b1;
                            data_q <= (MEM_ack && !MEM_err && load_q) ? load_ext : '0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESP: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign mem_active = rd_en_q || wr_en_q;

    assign req_ready  = ready_q;
    assign resp_valid = resp_q && !flush;
    assign resp_data  = resp_valid ? data_q : '0;
    assign resp_rd    = resp_valid ? rd_q : 5'd0;
    assign resp_err   = resp_valid && err_q;
    assign stall      = Reset && ((state != IDLE) || req_valid);
    assign MEM_rd_en  = rd_en_q;
    assign MEM_wr_en  = wr_en_q;
    assign MEM_addr   = mem_active ? addr_q : '0;
    assign MEM_WR_out = mem_active ? wdata_q : '0;
    assign MEM_type   = mem_active ? func3_q : 3'd0;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// tb_load_store_unit : vector table, flush/reset sequences and randomized
// transactions checked against a transaction-level model.
module tb_load_store_unit;
    localparam int T32 = 4;
    localparam int T64 = 6;

    logic CLK   = 1'b0;
    logic Reset = 1'b0;
    always #5 CLK = ~CLK;

    logic        sel = 1'b0, req_valid = 1'b0, req_load = 1'b0, flush = 1'b0;
    logic        MEM_ack = 1'b0, MEM_err = 1'b0;
    logic [2:0]  req_func3 = 3'd0;
    logic [4:0]  req_rd = 5'd0;
    logic [63:0] req_addr = '0, req_wdata = '0, MEM_data = '0;

    logic        rdy32, rv32, rerr32, st32, rden32, wren32;
    logic [31:0] rdata32, maddr32, mwr32;
    logic [4:0]  rrd32;
    logic [2:0]  mtype32;
    logic        rdy64, rv64, rerr64, st64, rden64, wren64;
    logic [63:0] rdata64, maddr64, mwr64;
    logic [4:0]  rrd64;
    logic [2:0]  mtype64;

    load_store_unit #(.XLEN(32), .TIMEOUT(T32)) u32 (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid && !sel), .req_ready(rdy32),
        .req_load(req_load), .req_func3(req_func3), .req_addr(req_addr[31:0]),
        .req_wdata(req_wdata[31:0]), .req_rd(req_rd),
        .resp_valid(rv32), .resp_data(rdata32), .resp_rd(rrd32), .resp_err(rerr32),
        .stall(st32), .flush(flush && !sel),
        .MEM_addr(maddr32), .MEM_WR_out(mwr32), .MEM_type(mtype32),
        .MEM_rd_en(rden32), .MEM_wr_en(wren32), .MEM_data(MEM_data[31:0]),
        .MEM_ack(MEM_ack && !sel), .MEM_err(MEM_err)
    );

    load_store_unit #(.XLEN(64), .TIMEOUT(T64)) u64 (
        .CLK(CLK), .Reset(Reset),
        .req_valid(req_valid && sel), .req_ready(rdy64),
        .req_load(req_load), .req_func3(req_func3), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .resp_valid(rv64), .resp_data(rdata64), .resp_rd(rrd64), .resp_err(rerr64),
        .stall(st64), .flush(flush && sel),
        .MEM_addr(maddr64), .MEM_WR_out(mwr64), .MEM_type(mtype64),
        .MEM_rd_en(rden64), .MEM_wr_en(wren64), .MEM_data(MEM_data),
        .MEM_ack(MEM_ack && sel), .MEM_err(MEM_err)
    );

    wire        o_ready = sel ? rdy64  : rdy32;
    wire        o_rv    = sel ? rv64   : rv32;
    wire        o_err   = sel ? rerr64 : rerr32;
    wire        o_stall = sel ? st64   : st32;
    wire        o_rden  = sel ? rden64 : rden32;
    wire        o_wren  = sel ? wren64 : wren32;
    wire [4:0]  o_rd    = sel ? rrd64  : rrd32;
    wire [2:0]  o_type  = sel ? mtype64 : mtype32;
    wire [63:0] o_data  = sel ? rdata64 : {32'd0, rdata32};
    wire [63:0] o_addr  = sel ? maddr64 : {32'd0, maddr32};
    wire [63:0] o_wout  = sel ? mwr64   : {32'd0, mwr32};

    typedef struct {
        logic        sel;
        logic        load;
        logic [2:0]  func3;
        logic [63:0] addr, wdata, mem_data;
        int          ack_delay;
        logic        mem_err;
        logic [4:0]  rd;
        logic        exp_mem, exp_err;
        logic [63:0] exp_data, exp_wout;
        logic [4:0]  exp_rd;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge CLK);
        #1;
    endtask

    function automatic vec_t mk(input logic s, input logic ld, input logic [2:0] f3,
                                input logic [63:0] a, input logic [63:0] wd, input logic [63:0] md,
                                input int dly, input logic me, input logic [4:0] rd,
                                input logic xm, input logic xe, input logic [63:0] xd,
                                input logic [63:0] xw);
        vec_t v;
        v.sel = s; v.load = ld; v.func3 = f3; v.addr = a; v.wdata = wd; v.mem_data = md;
        v.ack_delay = dly; v.mem_err = me; v.rd = rd;
        v.exp_mem = xm; v.exp_err = xe; v.exp_data = xd; v.exp_wout = xw;
        v.exp_rd = ld ? rd : 5'd0;
        return v;
    endfunction

    // Transaction-level reference: what the response must be, from the access rules.
    function automatic vec_t model(input vec_t v);
        vec_t        r;
        int          x, tmo, nbytes;
        logic [63:0] mask, raw, xmask;
        logic        legal, mis;
        r      = v;
        x      = v.sel ? 64 : 32;
        tmo    = v.sel ? T64 : T32;
        xmask  = (x == 64) ? '1 : 64'hFFFF_FFFF;
        nbytes = 1 << v.func3[1:0];
        mask   = (nbytes == 8) ? '1 : ((64'd1 << (8 * nbytes)) - 64'd1);
        if (v.load)
            legal = (v.func3 != 3'd7) && (x == 64 || (v.func3 != 3'd3 && v.func3 != 3'd6));
        else
            legal = (int'(v.func3) < ((x == 64) ? 4 : 3));
        mis = (v.addr % nbytes) != 0;
        r.exp_mem  = legal && !mis;
        r.exp_rd   = v.load ? v.rd : 5'd0;
        r.exp_wout = (!v.load && r.exp_mem) ? (v.wdata & mask) : 64'd0;
        if (!r.exp_mem || v.ack_delay >= tmo) r.exp_err = 1'b1;
        else                                  r.exp_err = v.mem_err;
        raw = v.mem_data & mask;
        if (!v.func3[2] && raw[8 * nbytes - 1]) raw = raw | ~mask;
        r.exp_data = (v.load && !r.exp_err) ? (raw & xmask) : 64'd0;
        return r;
    endfunction

    task automatic run_txn(input vec_t v);
        int tmo, waits;
        tmo = v.sel ? T64 : T32;
        sel = v.sel; flush = 1'b0; MEM_ack = 1'b0;
        req_load = v.load; req_func3 = v.func3; req_addr = v.addr;
        req_wdata = v.wdata; req_rd = v.rd; req_valid = 1'b1;
        #1;
        chk("idle_ready", o_ready, 1'b1);
        chk("idle_stall_on_valid", o_stall, 1'b1);
        step;
        // Scramble request inputs: the captured request must not follow them.
        req_valid = 1'b0; req_load = ~req_load; req_func3 = 3'($urandom);
        req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom}; req_rd = 5'($urandom);
        if (v.exp_mem) begin
            waits = (v.ack_delay + 1 < tmo) ? v.ack_delay + 1 : tmo;
            for (int c = 0; c < waits; c++) begin
                MEM_ack = (c == v.ack_delay); MEM_data = v.mem_data; MEM_err = v.mem_err;
                #1;
                chk("wait_rd_en", o_rden, v.load);
                chk("wait_wr_en", o_wren, !v.load);
                chk("wait_addr", o_addr, v.addr);
                chk("wait_type", o_type, v.func3);
                chk("wait_wr_out", o_wout, v.exp_wout);
                chk("wait_stall", o_stall, 1'b1);
                chk("wait_no_resp", o_rv, 1'b0);
                step;
                MEM_ack = 1'b0; MEM_err = 1'b0; MEM_data = {$urandom, $urandom};
            end
        end
        #1;
        chk("resp_valid", o_rv, 1'b1);
        chk("resp_err", o_err, v.exp_err);
        chk("resp_data", o_data, v.exp_data);
        chk("resp_rd", o_rd, v.exp_rd);
        chk("resp_mem_idle", {o_rden, o_wren, o_addr != 64'd0, o_wout != 64'd0}, 4'd0);
        step;
        #1;
        chk("after_resp_valid", o_rv, 1'b0);
        chk("after_resp_ready", o_ready, 1'b1);
        chk("after_resp_stall", o_stall, 1'b0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];

        // Reset behaviour
        req_valid = 1'b1;
        #2;
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_stall", o_stall, 1'b0);
        chk("rst_resp_valid", o_rv, 1'b0);
        chk("rst_rd_en", o_rden, 1'b0);
        step; step;
        Reset = 1'b1; req_valid = 1'b0;
        #1;
        chk("rel_ready_before_edge", o_ready, 1'b0);
        step;
        #1;
        chk("rel_ready_after_edge", o_ready, 1'b1);

        // Directed vectors
        tbl.push_back(mk(0, 1, 3'd0, 'h103, 0, 'hF0, 3, 0, 5, 1, 0, 'hFFFF_FFF0, 0));
        tbl.push_back(mk(0, 1, 3'd2, 'h102, 0, 0, 0, 0, 7, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3'd1, 'h40, 'h1234_5678, 0, 1, 0, 3, 1, 0, 0, 'h5678));
        tbl.push_back(mk(0, 1, 3'd2, 'h200, 0, 'hDEAD, 99, 0, 3, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 3'd4, 'h7, 0, 'h80, 0, 0, 1, 1, 0, 'h80, 0));
        tbl.push_back(mk(0, 1, 3'd1, 'h2, 0, 'h8001, 2, 0, 2, 1, 0, 'hFFFF_8001, 0));
        tbl.push_back(mk(0, 1, 3'd5, 'h6, 0, 'hABCD_8001, 1, 0, 6, 1, 0, 'h8001, 0));
        tbl.push_back(mk(0, 1, 3'd3, 'h8, 0, 0, 0, 0, 8, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3'd2, 'h10, 'hCAFE_BABE, 0, 2, 1, 9, 1, 1, 0, 'hCAFE_BABE));
        tbl.push_back(mk(0, 0, 3'd4, 'h20, 'h55, 0, 0, 0, 10, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 3'd0, 'h13, 'hFFFF_FFA5, 0, 0, 0, 18, 1, 0, 0, 'hA5));
        tbl.push_back(mk(1, 1, 3'd6, 'h8, 0, 'hFFFF_FFFF_8000_0000, 2, 0, 4, 1, 0, 'h8000_0000, 0));
        tbl.push_back(mk(1, 1, 3'd3, 'h10, 0, 'h8000_0000_0000_0001, 0, 0, 11, 1, 0, 'h8000_0000_0000_0001, 0));
        tbl.push_back(mk(1, 1, 3'd2, 'h4, 0, 'h8000_0000, 1, 0, 12, 1, 0, 'hFFFF_FFFF_8000_0000, 0));
        tbl.push_back(mk(1, 0, 3'd3, 'h18, 'h1122_3344_5566_7788, 0, 3, 0, 13, 1, 0, 0, 'h1122_3344_5566_7788));
        tbl.push_back(mk(1, 1, 3'd3, 'h4, 0, 0, 0, 0, 14, 0, 1, 0, 0));
        tbl.push_back(mk(1, 1, 3'd0, 'h33, 0, 'h7F, 5, 0, 15, 1, 0, 'h7F, 0));
        tbl.push_back(mk(1, 1, 3'd0, 'h33, 0, 'h7F, 6, 0, 16, 1, 1, 0, 0));
        tbl.push_back(mk(1, 0, 3'd4, 'h0, 'h1, 0, 0, 0, 17, 0, 1, 0, 0));
        foreach (tbl[i]) run_txn(tbl[i]);

        // Flush during WAIT: transaction completes on the bus, no response.
        sel = 1'b0; req_load = 1'b1; req_func3 = 3'd2; req_addr = 'h100; req_rd = 5'd9;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0; flush = 1'b1;
        #1; chk("flushW_rd_en_c0", o_rden, 1'b1);
        step;
        flush = 1'b0; MEM_ack = 1'b1; MEM_data = 'h1234;
        #1; chk("flushW_rd_en_ack", o_rden, 1'b1);
        step;
        MEM_ack = 1'b0;
        #1;
        chk("flushW_no_resp", o_rv, 1'b0);
        chk("flushW_ready", o_ready, 1'b1);
        chk("flushW_rd_en_off", o_rden, 1'b0);
        step;
        #1; chk("flushW_no_resp_late", o_rv, 1'b0);

        // Flush in RESP suppresses the error response.
        req_load = 1'b1; req_func3 = 3'd2; req_addr = 'h101; req_valid = 1'b1;
        step;
        req_valid = 1'b0; flush = 1'b1;
        #1; chk("flushR_no_resp", o_rv, 1'b0);
        step;
        flush = 1'b0;
        #1;
        chk("flushR_ready", o_ready, 1'b1);
        chk("flushR_no_resp_late", o_rv, 1'b0);

        // Flush in IDLE ignores the concurrent request.
        req_func3 = 3'd0; req_addr = 'h0; req_valid = 1'b1; flush = 1'b1;
        #1; chk("flushI_stall", o_stall, 1'b1);
        step;
        req_valid = 1'b0; flush = 1'b0;
        #1;
        chk("flushI_ready", o_ready, 1'b1);
        chk("flushI_no_mem", o_rden, 1'b0);
        chk("flushI_no_resp", o_rv, 1'b0);

        // Reset in the middle of a 64-bit WAIT.
        sel = 1'b1; req_load = 1'b1; req_func3 = 3'd6; req_addr = 'h8; req_rd = 5'd4;
        req_valid = 1'b1;
        step;
        req_valid = 1'b0;
        #1; chk("rstW_rd_en_before", o_rden, 1'b1);
        #1; Reset = 1'b0;
        #1;
        chk("rstW_rd_en_async", o_rden, 1'b0);
        chk("rstW_addr_async", o_addr, 64'd0);
        chk("rstW_ready_async", o_ready, 1'b0);
        step;
        MEM_ack = 1'b1; MEM_data = 'hFFFF_FFFF_8000_0000;
        step;
        Reset = 1'b1;
        #1; chk("rstW_ready_pre_edge", o_ready, 1'b0);
        step;
        #1;
        chk("rstW_ready_post_edge", o_ready, 1'b1);
        chk("rstW_no_resp", o_rv, 1'b0);
        chk("rstW_no_mem", o_rden, 1'b0);
        step;
        MEM_ack = 1'b0;
        #1; chk("rstW_no_resp_late", o_rv, 1'b0);
        run_txn(mk(1, 1, 3'd6, 'h8, 0, 'hFFFF_FFFF_8000_0000, 1, 0, 4, 1, 0, 'h8000_0000, 0));

        // Randomized transactions against the model
        for (int i = 0; i < 300; i++) begin
            vec_t v;
            v.sel      = 1'($urandom_range(0, 1));
            v.load     = 1'($urandom_range(0, 1));
            v.func3    = 3'($urandom_range(0, 7));
            v.addr     = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) v.addr[2:0] = 3'd0;
            v.wdata    = {$urandom, $urandom};
            v.mem_data = {$urandom, $urandom};
            if (!v.sel) begin
                v.addr[63:32] = '0; v.wdata[63:32] = '0; v.mem_data[63:32] = '0;
            end
            v.rd        = 5'($urandom);
            v.ack_delay = $urandom_range(0, (v.sel ? T64 : T32) + 1);
            v.mem_err   = ($urandom_range(0, 7) == 0);
            run_txn(model(v));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
